// File: rtl/char_mem_pkg.sv
// Shared constants and FSM state type for the glyph-store scheduler.
package char_mem_pkg;

  localparam int unsigned CHAR_COLS = 4;
  localparam int unsigned CHAR_ROWS = 5;
  localparam int unsigned CHAR_BITS = CHAR_COLS * CHAR_ROWS;
  localparam int unsigned X_W       = 2;
  localparam int unsigned Y_W       = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } load_state_t;

endpackage

// File: rtl/char_load_counter.sv
// Raster x/y counter that walks the 4x5 glyph cells in write order.
module char_load_counter
  import char_mem_pkg::*;
(
  input  logic           clock,
  input  logic           rst,
  input  logic           clr,
  input  logic           en,
  output logic [X_W-1:0] x,
  output logic [Y_W-1:0] y,
  output logic           last_c
);

  assign last_c = (x == X_W'(CHAR_COLS - 1)) && (y == Y_W'(CHAR_ROWS - 1));

  // Saturates at the last cell so it never leaves the glyph.
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      x <= '0;
      y <= '0;
    end else if (clr) begin
      x <= '0;
      y <= '0;
    end else if (en && !last_c) begin
      if (x == X_W'(CHAR_COLS - 1)) begin
        x <= '0;
        y <= y + Y_W'(1);
      end else begin
        x <= x + X_W'(1);
      end
    end
  end

endmodule

// File: rtl/char_mem_sched.sv
// Arbiter/sequencer sharing the char_memory port between video reads and host loads.
// Optional starvation guard for host loads: CHAR_MEM_STARVE_GUARD_EN.
module char_mem_sched
  import char_mem_pkg::*;
`ifdef CHAR_MEM_STARVE_GUARD_EN
#(
  parameter int unsigned STALL_MAX = 8
)
`endif
(
  input  logic                 clock,
  input  logic                 rst,
  input  logic                 vid_req,
  input  logic [X_W-1:0]       vid_x,
  input  logic [Y_W-1:0]       vid_y,
  output logic                 vid_pixel,
  output logic                 vid_valid,
  input  logic                 host_load,
  input  logic [CHAR_BITS-1:0] host_glyph,
  output logic                 host_busy,
  output logic                 host_done,
  output logic                 mem_write,
  output logic [X_W-1:0]       mem_x,
  output logic [Y_W-1:0]       mem_y,
  output logic                 mem_data,
  input  logic                 mem_rdata
);

  load_state_t          state;
  load_state_t          next_state;
  logic [CHAR_BITS-1:0] glyph;
  logic [X_W-1:0]       cnt_x;
  logic [Y_W-1:0]       cnt_y;
  logic                 cnt_last_c;
  logic                 load_start_c;
  logic                 force_c;
  logic                 vid_grant_c;
  logic                 host_grant_c;

`ifdef CHAR_MEM_STARVE_GUARD_EN
  localparam int unsigned STALL_W = $clog2(STALL_MAX + 1);
  logic [STALL_W-1:0] stall_cnt;

  // After STALL_MAX video-won LOAD cycles, the host takes the next slot.
  assign force_c = (state == LOAD) && (stall_cnt == STALL_W'(STALL_MAX));

  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (host_grant_c) begin
      stall_cnt <= '0;
    end else if ((state == LOAD) && vid_req) begin
      stall_cnt <= stall_cnt + STALL_W'(1);
    end
  end
`else
  assign force_c = 1'b0;
`endif

  assign vid_grant_c  = vid_req & ~force_c;
  assign host_grant_c = (state == LOAD) & (~vid_req | force_c);

  assign mem_write = host_grant_c;
  assign mem_x     = vid_grant_c ? vid_x : cnt_x;
  assign mem_y     = vid_grant_c ? vid_y : cnt_y;
  assign mem_data  = glyph[{cnt_y, cnt_x}];

  char_load_counter u_counter (
    .clock  (clock),
    .rst    (rst),
    .clr    (load_start_c),
    .en     (host_grant_c),
    .x      (cnt_x),
    .y      (cnt_y),
    .last_c (cnt_last_c)
  );

  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state   = state;
    load_start_c = 1'b0;
    case (state)
      IDLE: begin
        if (host_load) begin
          next_state   = LOAD;
          load_start_c = 1'b1;
        end
      end
      LOAD:    if (host_grant_c && cnt_last_c) next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Status flags track the state being entered so they line up with it.
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      glyph     <= '0;
      vid_pixel <= 1'b0;
      vid_valid <= 1'b0;
      host_busy <= 1'b0;
      host_done <= 1'b0;
    end else begin
      if (load_start_c) glyph <= host_glyph;
      host_busy <= (next_state != IDLE);
      host_done <= (next_state == DONE);
      vid_valid <= vid_grant_c;
      if (vid_grant_c) vid_pixel <= (vid_y < Y_W'(CHAR_ROWS)) ? mem_rdata : 1'b0;
    end
  end

endmodule

// File: doc/char_mem_sched.md
Name: char_mem_sched

Overview:
- Sequencer and arbiter in front of the 4x5 one-bit glyph store (`char_memory`). It shares that store's single x/y address port between two requesters:
  - the VGA pixel pipeline (read, fixed latency);
  - a host glyph loader (20-bit bulk write driven from the Arduino command side).
- It sits between the command decoder and one `char_memory` instance, and drives that instance's write, x, y and data_in inputs.

Parameters:
- STALL_MAX, 8, consecutive host-stall cycles tolerated before the starvation guard forces one host slot. Used only with CHAR_MEM_STARVE_GUARD_EN.

Ports:
- clock  in  1  system clock; all flops are rising-edge.
- rst  in  1  asynchronous, active-high reset.
- vid_req  in  1  video wants the pixel at vid_x/vid_y this cycle.
- vid_x  in  2  glyph column 0-3.
- vid_y  in  3  glyph row 0-4; values 5-7 are out of range.
- vid_pixel  out  1  registered read data.
- vid_valid  out  1  vid_pixel holds data for the request made in the previous cycle.
- host_load  in  1  start pulse for a glyph load.
- host_glyph  in  20  glyph image; bit i maps to row i/4, column i%4.
- host_busy  out  1  a load is in progress.
- host_done  out  1  one-cycle pulse when a load completes.
- mem_write  out  1  to char_memory write.
- mem_x  out  2  to char_memory x.
- mem_y  out  3  to char_memory y.
- mem_data  out  1  to char_memory data_in.
- mem_rdata  in  1  from char_memory data_out (combinational from x/y).

Behaviour:
- Reset (async, rst=1): state=IDLE, load counter x=0/y=0, glyph latch=0, vid_pixel=0, vid_valid=0, host_busy=0, host_done=0, stall counter=0.
- FSM states: IDLE, LOAD, DONE.
  - IDLE -> LOAD when host_load=1 at a clock edge. The same edge latches host_glyph and clears the counter.
  - LOAD -> DONE on the edge that performs the write at (x=3,y=4).
  - DONE -> IDLE unconditionally after one cycle.
- host_busy=1 in LOAD and DONE. host_done=1 only in DONE. host_load is ignored outside IDLE.
- Grant (combinational):
  - vid_grant = vid_req.
  - host_grant = (state==LOAD) & ~vid_req.
- Address mux:
  - vid_grant: mem_x/mem_y = vid_x/vid_y.
  - Otherwise: mem_x/mem_y = load counter.
- Write strobe: mem_write = host_grant. mem_data = latched glyph bit [y*4+x].
- Counter advance:
  - Advances only on a host_grant edge.
  - x increments; at x=3, x wraps to 0 and y increments.
  - The counter never exceeds (3,4).
- Load duration: the uncontended load is 20 LOAD cycles. host_done is seen 21 cycles after the host_load edge. Each video-granted cycle during LOAD adds one cycle.
- Video read:
  - Latency is 1. On an edge with vid_grant: vid_pixel <= (vid_y<5 ? mem_rdata : 0) and vid_valid <= 1.
  - On an edge without vid_grant: vid_valid <= 0 and vid_pixel holds.
- Read/write coincidence: video always wins the port. A video read of a cell being loaded returns the pre-write value.
- Reset mid-load: returns to IDLE immediately; the partial load is abandoned and no host_done pulse is produced. Memory contents are not restored by this block.

Optional Feature:
- CHAR_MEM_STARVE_GUARD_EN.
- Defined:
  - A stall counter increments on each LOAD cycle with vid_req=1 and clears on any host_grant.
  - When the count reaches STALL_MAX, the next cycle forces host_grant=1 and vid_grant=0, even with vid_req=1.
  - On that edge vid_valid <= 0, the write proceeds, and the counter clears.
- Undefined: the stall counter is absent, video has strict priority, and a load may stall indefinitely.

Decomposition:
- Package char_mem_pkg: CHAR_COLS=4, CHAR_ROWS=5, CHAR_BITS=20, the state enum type (IDLE/LOAD/DONE), and the x/y width constants.
- Sub-module char_load_counter: the x/y raster counter with enable, clear and a last flag at (3,4).

Test Plan:
- Uncontended load:
  - Stimulus: host_glyph=20'hA5A5A with vid_req=0 throughout, behind a real char_memory.
  - Required: host_busy high for 21 cycles; exactly 20 mem_write cycles; host_done pulses once; a readback of all 20 cells matches the glyph bit by bit.
- Video latency:
  - Stimulus: in IDLE, vid_req=1 at (x=2,y=1) for one cycle, with the default memory row1=4'b1010.
  - Required: next cycle vid_valid=1 and vid_pixel=0 (bit 2 of 4'b1010); the following cycle vid_valid=0.
- Contention:
  - Stimulus: vid_req held high for 3 cycles mid-load.
  - Required: mem_write=0 during those cycles; host_done arrives 24 cycles after host_load; final contents are still correct.
- Ignored and out-of-range inputs:
  - Stimulus: host_load re-pulsed during LOAD.
  - Required: no restart and the original glyph is written.
  - Stimulus: vid_y=6.
  - Required: vid_pixel=0 and vid_valid=1.
- Reset mid-load:
  - Stimulus: rst asserted asynchronously after 7 writes.
  - Required: host_busy=0, vid_valid=0, and no host_done; after release, a new load completes normally.
- Starvation guard (CHAR_MEM_STARVE_GUARD_EN, STALL_MAX=8):
  - Stimulus: vid_req held high for the whole load.
  - Required: one write every 9 cycles; vid_valid=0 on each forced cycle; the load completes in 180 cycles.
